spi_job_scheduler: RTL



---
 rtl/spi_job_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/spi_job_scheduler.sv
// Runs N drawing jobs in index order on one shared SPI bus, muxing only the active job onto it.
// Adds an optional gap between jobs, a per-job watchdog, and a restart path out of FIN or ERR.
module spi_job_scheduler #(
  parameter int N_JOBS      = 5,
  parameter int JW          = 3,
  parameter int GAP         = 16,
  parameter int TIMEOUT     = 0,
  parameter int RESTART_IDX = 1
) (
  input  logic              i_clk,
  input  logic              w_rst,
  input  logic              i_restart,
  output logic [N_JOBS-1:0] o_start,
  input  logic [N_JOBS-1:0] i_done,
  input  logic [N_JOBS-1:0] i_mosi,
  input  logic [N_JOBS-1:0] i_dc,
  input  logic [N_JOBS-1:0] i_cs,
  output logic              o_mosi,
  output logic              o_dc,
  output logic              o_cs,
  output logic [JW-1:0]     o_job,
  output logic              o_busy,
  output logic              o_fin,
  output logic              o_error
);

  typedef enum logic [2:0] {S_LAUNCH, S_WAIT, S_GAP, S_FIN, S_ERR} state_t;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t          state, state_nx;
  logic [JW-1:0]   job_nx;
  logic [31:0]     wdog, wdog_nx;
  logic [GW-1:0]   gcnt, gcnt_nx;
  logic [N_JOBS-1:0] start_vec;
  logic            done_cur;
  logic            wd_exp;

  assign done_cur  = i_done[o_job];
  assign wd_exp    = (TIMEOUT != 0) && (wdog == 32'(TIMEOUT - 1));
  assign start_vec = {{(N_JOBS-1){1'b0}}, 1'b1} << o_job;

  always_comb begin
    state_nx = state;
    job_nx   = o_job;
    wdog_nx  = wdog;
    gcnt_nx  = gcnt;
    case (state)
      S_LAUNCH: begin
        wdog_nx  = '0;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        wdog_nx = wdog + 32'd1;
        // done takes priority over a watchdog expiry in the same cycle
        if (done_cur) begin
          if (o_job == JW'(N_JOBS - 1)) begin
            state_nx = S_FIN;
          end else begin
            job_nx   = o_job + JW'(1);
            gcnt_nx  = '0;
            state_nx = (GAP == 0) ? S_LAUNCH : S_GAP;
          end
        end else if (wd_exp) begin
          state_nx = S_ERR;
        end
      end
      S_GAP: begin
        if (gcnt == GW'(GAP - 1)) state_nx = S_LAUNCH;
        else                      gcnt_nx  = gcnt + GW'(1);
      end
      S_FIN, S_ERR: begin
        if (i_restart) begin
          job_nx   = JW'(RESTART_IDX);
          state_nx = S_LAUNCH;
        end
      end
      default: state_nx = S_LAUNCH;
    endcase
  end

  // flags are registered from next state so they line up with the state register
  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      state   <= S_LAUNCH;
      o_job   <= '0;
      wdog    <= '0;
      gcnt    <= '0;
      o_start <= '0;
      o_busy  <= 1'b0;
      o_fin   <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state   <= state_nx;
      o_job   <= job_nx;
      wdog    <= wdog_nx;
      gcnt    <= gcnt_nx;
      o_start <= (state == S_LAUNCH) ? start_vec : '0;
      o_busy  <= (state_nx == S_LAUNCH) || (state_nx == S_WAIT) || (state_nx == S_GAP);
      o_fin   <= (state_nx == S_FIN);
      o_error <= (state_nx == S_ERR);
    end
  end

  always_comb begin
    o_mosi = 1'b0;
    o_dc   = 1'b0;
    o_cs   = 1'b1;
    if (state == S_WAIT) begin
      o_mosi = i_mosi[o_job];
      o_dc   = i_dc[o_job];
      o_cs   = i_cs[o_job];
    end
  end

endmodule
